// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp32_pkg
// Purpose  : Shared binary32 constants, operand classes and divider states.
// Revision : 1.0  initial release
// ============================================================================
package fp32_pkg;

    localparam int          BIAS = 127;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] INF  = 32'h7F80_0000;

    // Enumerators carry a CLS_ prefix so they cannot collide with the INF constant.
    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } div_state_e;

    function automatic fp_class_e fp_classify(input logic [7:0] exp_f, input logic [22:0] frac);
        fp_class_e cls;
        if (exp_f == 8'd0) begin
            cls = CLS_ZERO;
        end else if (exp_f != 8'hFF) begin
            cls = CLS_NORM;
        end else if (frac == 23'd0) begin
            cls = CLS_INF;
        end else begin
            cls = CLS_NAN;
        end
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp32_divider_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : fp32_divider_seq_if
// Purpose  : Operand and result handshake bundle for the sequential divider.
// Revision : 1.0  initial release
// ============================================================================
interface fp32_divider_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] q;
    logic        flag_invalid;
    logic        flag_dz;
    logic        flag_ovf;
    logic        flag_unf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q, flag_invalid, flag_dz, flag_ovf, flag_unf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q, flag_invalid, flag_dz, flag_ovf, flag_unf
    );

endinterface
`default_nettype wire

// File: rtl/fp32_unpack.sv
`default_nettype none
// ============================================================================
// Module   : fp32_unpack
// Purpose  : Split a binary32 word into sign, exponent, mantissa and class.
// Revision : 1.0  initial release
// ============================================================================
module fp32_unpack
    import fp32_pkg::*;
(
    input  logic [31:0] i_word,
    output logic        o_sign,
    output logic [7:0]  o_exp,
    output logic [23:0] o_mant,
    output fp_class_e   o_cls
);

    assign o_sign = i_word[31];
    assign o_exp  = i_word[30:23];
    // Hidden bit is always set; zero-class operands never reach the mantissa loop.
    assign o_mant = {1'b1, i_word[22:0]};
    assign o_cls  = fp_classify(i_word[30:23], i_word[22:0]);

endmodule
`default_nettype wire

// File: rtl/fp32_divider_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp32_divider_seq
// Purpose  : Sequential binary32 divider, radix-2 restoring loop, FTZ/DAZ, RNE.
// Revision : 1.0  initial release
// ============================================================================
module fp32_divider_seq
    import fp32_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    fp32_divider_seq_if.slave  bus
);

    div_state_e         state_q, state_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [24:0]        rem_q, rem_d;
    logic [23:0]        div_q, div_d;
    logic [25:0]        qm_q, qm_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [31:0]        q_q, q_d;
    logic               flag_invalid_q, flag_invalid_d;
    logic               flag_dz_q, flag_dz_d;
    logic               flag_ovf_q, flag_ovf_d;
    logic               flag_unf_q, flag_unf_d;

    logic               w_a_sign, w_b_sign;
    logic [7:0]         w_a_exp, w_b_exp;
    logic [23:0]        w_a_mant, w_b_mant;
    fp_class_e          w_a_cls, w_b_cls;

    fp32_unpack u_unpack_a (
        .i_word (bus.a),
        .o_sign (w_a_sign),
        .o_exp  (w_a_exp),
        .o_mant (w_a_mant),
        .o_cls  (w_a_cls)
    );

    fp32_unpack u_unpack_b (
        .i_word (bus.b),
        .o_sign (w_b_sign),
        .o_exp  (w_b_exp),
        .o_mant (w_b_mant),
        .o_cls  (w_b_cls)
    );

    logic               w_sign;
    logic               w_special;
    logic [31:0]        w_spec_q;
    logic               w_spec_inv;
    logic               w_spec_dz;
    logic signed [9:0]  w_exp_init;

    assign w_sign     = w_a_sign ^ w_b_sign;
    assign w_special  = (w_a_cls != CLS_NORM) || (w_b_cls != CLS_NORM);
    assign w_exp_init = $signed({2'b00, w_a_exp}) - $signed({2'b00, w_b_exp}) + 10'(BIAS);

    always_comb begin
        w_spec_q   = {w_sign, 31'd0};
        w_spec_inv = 1'b0;
        w_spec_dz  = 1'b0;
        if ((w_a_cls == CLS_NAN) || (w_b_cls == CLS_NAN) ||
            ((w_a_cls == CLS_ZERO) && (w_b_cls == CLS_ZERO)) ||
            ((w_a_cls == CLS_INF) && (w_b_cls == CLS_INF))) begin
            w_spec_q   = QNAN;
            w_spec_inv = 1'b1;
        end else if (w_b_cls == CLS_ZERO) begin
            // inf / 0 is an ordinary infinity; only finite non-zero / 0 raises dz.
            w_spec_q  = INF | {w_sign, 31'd0};
            w_spec_dz = (w_a_cls != CLS_INF);
        end else if (w_a_cls == CLS_INF) begin
            w_spec_q = INF | {w_sign, 31'd0};
        end
    end

    // One restoring step: the remainder always stays below twice the divisor.
    logic               w_ge;
    logic [24:0]        w_sub;

    assign w_ge  = (rem_q >= {1'b0, div_q});
    assign w_sub = w_ge ? (rem_q - {1'b0, div_q}) : rem_q;

    logic               w_hi;
    logic [23:0]        w_mant;
    logic               w_guard;
    logic               w_sticky;
    logic               w_round_up;
    logic [24:0]        w_mant_sum;
    logic signed [9:0]  w_exp_adj;
    logic signed [9:0]  w_exp_rnd;
    logic               w_unused_bits;

    assign w_hi       = qm_q[25];
    assign w_mant     = w_hi ? qm_q[25:2] : qm_q[24:1];
    assign w_guard    = w_hi ? qm_q[1] : qm_q[0];
    assign w_sticky   = (w_hi & qm_q[0]) | (rem_q != 25'd0);
    assign w_exp_adj  = w_hi ? exp_q : (exp_q - 10'sd1);
    assign w_round_up = w_guard & (w_sticky | w_mant[0]);
    assign w_mant_sum = {1'b0, w_mant} + {24'd0, w_round_up};
    // A carry-out leaves the fraction bits at zero, which is exactly 1.0 x 2^(e+1).
    assign w_exp_rnd  = w_mant_sum[24] ? (w_exp_adj + 10'sd1) : w_exp_adj;

    assign w_unused_bits = w_sub[24] ^ w_mant_sum[23];

    always_comb begin
        state_d        = state_q;
        sign_d         = sign_q;
        exp_d          = exp_q;
        rem_d          = rem_q;
        div_d          = div_q;
        qm_d           = qm_q;
        cnt_d          = cnt_q;
        q_d            = q_q;
        flag_invalid_d = flag_invalid_q;
        flag_dz_d      = flag_dz_q;
        flag_ovf_d     = flag_ovf_q;
        flag_unf_d     = flag_unf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d         = w_sign;
                    flag_invalid_d = 1'b0;
                    flag_dz_d      = 1'b0;
                    flag_ovf_d     = 1'b0;
                    flag_unf_d     = 1'b0;
                    if (w_special) begin
                        q_d            = w_spec_q;
                        flag_invalid_d = w_spec_inv;
                        flag_dz_d      = w_spec_dz;
                        state_d        = DONE;
                    end else begin
                        rem_d   = {1'b0, w_a_mant};
                        div_d   = w_b_mant;
                        qm_d    = 26'd0;
                        cnt_d   = 5'd0;
                        exp_d   = w_exp_init;
                        state_d = DIV;
                    end
                end
            end

            DIV: begin
                rem_d = {w_sub[23:0], 1'b0};
                qm_d  = {qm_q[24:0], w_ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd25) begin
                    state_d = ROUND;
                end
            end

            ROUND: begin
                if (w_exp_rnd >= 10'sd255) begin
                    q_d        = INF | {sign_q, 31'd0};
                    flag_ovf_d = 1'b1;
                end else if (w_exp_rnd <= 10'sd0) begin
                    q_d        = {sign_q, 31'd0};
                    flag_unf_d = 1'b1;
                end else begin
                    q_d = {sign_q, w_exp_rnd[7:0], w_mant_sum[22:0]};
                end
                state_d = DONE;
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            sign_q         <= 1'b0;
            exp_q          <= 10'sd0;
            rem_q          <= 25'd0;
            div_q          <= 24'd0;
            qm_q           <= 26'd0;
            cnt_q          <= 5'd0;
            q_q            <= 32'd0;
            flag_invalid_q <= 1'b0;
            flag_dz_q      <= 1'b0;
            flag_ovf_q     <= 1'b0;
            flag_unf_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            sign_q         <= sign_d;
            exp_q          <= exp_d;
            rem_q          <= rem_d;
            div_q          <= div_d;
            qm_q           <= qm_d;
            cnt_q          <= cnt_d;
            q_q            <= q_d;
            flag_invalid_q <= flag_invalid_d;
            flag_dz_q      <= flag_dz_d;
            flag_ovf_q     <= flag_ovf_d;
            flag_unf_q     <= flag_unf_d;
        end
    end

    assign bus.in_ready     = (state_q == IDLE);
    assign bus.out_valid    = (state_q == DONE);
    assign bus.q            = q_q;
    assign bus.flag_invalid = flag_invalid_q;
    assign bus.flag_dz      = flag_dz_q;
    assign bus.flag_ovf     = flag_ovf_q;
    assign bus.flag_unf     = flag_unf_q;

endmodule
`default_nettype wire

// File: tb/tb_fp32_divider_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_divider_seq
// Purpose  : Scoreboard bench for fp32_divider_seq with an arithmetic reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp32_divider_seq;

    typedef struct {
        logic [31:0] q;
        logic [3:0]  f;      // {invalid, dz, ovf, unf}
        int          lat;
        int          acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   cyc;
    exp_t sb[$];

    logic bp_mode;
    int   bp_left;
    logic holding;

    fp32_divider_seq_if bus ();

    fp32_divider_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [3:0] dut_flags();
        return {bus.flag_invalid, bus.flag_dz, bus.flag_ovf, bus.flag_unf};
    endfunction

    // Reference: exact quotient by integer division, then RNE from the remainder.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        logic   s;
        int     ea, eb, ex;
        logic   az, an, ai, bz, bn, bi;
        longint ma, mb, n, m, r;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        az = (ea == 0);
        bz = (eb == 0);
        an = (ea == 255) && (a[22:0] != 0);
        bn = (eb == 255) && (b[22:0] != 0);
        ai = (ea == 255) && (a[22:0] == 0);
        bi = (eb == 255) && (b[22:0] == 0);
        e.q   = {s, 31'd0};
        e.f   = 4'b0000;
        e.lat = 1;
        e.acc = 0;
        if (an || bn || (az && bz) || (ai && bi)) begin
            e.q = 32'h7FC00000;
            e.f = 4'b1000;
        end else if (bz) begin
            e.q = {s, 8'hFF, 23'd0};
            if (!ai) e.f = 4'b0100;
        end else if (ai) begin
            e.q = {s, 8'hFF, 23'd0};
        end else if (!(az || bi)) begin
            e.lat = 28;
            ma = longint'({1'b1, a[22:0]});
            mb = longint'({1'b1, b[22:0]});
            ex = ea - eb + 127;
            if (ma >= mb) begin
                n = ma << 23;
            end else begin
                n = ma << 24;
                ex--;
            end
            m = n / mb;
            r = n % mb;
            if ((2 * r > mb) || ((2 * r == mb) && (m % 2 == 1))) m++;
            if (m == (longint'(1) << 24)) begin
                m = longint'(1) << 23;
                ex++;
            end
            if (ex >= 255) begin
                e.q = {s, 8'hFF, 23'd0};
                e.f = 4'b0010;
            end else if (ex <= 0) begin
                e.q = {s, 31'd0};
                e.f = 4'b0001;
            end else begin
                e.q = {s, ex[7:0], m[22:0]};
            end
        end
        return e;
    endfunction

    task automatic drive(input logic [31:0] av, input logic [31:0] bv, input exp_t e);
        int g;
        g = 0;
        @(negedge clk);
        while (!bus.in_ready && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (!bus.in_ready) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: got in_ready=0, expected 1");
        end else begin
            bus.in_valid = 1'b1;
            bus.a        = av;
            bus.b        = bv;
            e.acc        = cyc + 1;
            sb.push_back(e);
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.a        = $urandom;
            bus.b        = $urandom;
        end
    endtask

    task automatic issue_dir(input logic [31:0] av, input logic [31:0] bv,
                             input logic [31:0] qv, input logic [3:0] fv, input int lat);
        exp_t e;
        e.q   = qv;
        e.f   = fv;
        e.lat = lat;
        e.acc = 0;
        drive(av, bv, e);
    endtask

    task automatic issue_rand(input logic [31:0] av, input logic [31:0] bv);
        drive(av, bv, model(av, bv));
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((sb.size() != 0 || !bus.in_ready) && g < 300) begin
            @(negedge clk);
            g++;
        end
        tests++;
        if (sb.size() != 0 || !bus.in_ready) begin
            fails++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
        end
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0: begin
                case ($urandom_range(0, 5))
                    0: v = 32'h00000000;
                    1: v = 32'h80000000;
                    2: v = 32'h7F800000;
                    3: v = 32'hFF800000;
                    4: v = 32'h7FC00001;
                    default: v = 32'h00000123;
                endcase
            end
            1: v = $urandom;
            2: v = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 8)), 23'($urandom)};
            3: v = {1'($urandom_range(0, 1)), 8'($urandom_range(246, 254)), 23'($urandom)};
            default: v = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
        endcase
        return v;
    endfunction

    // Consumer: random acceptance, or a fixed stall after out_valid when bp_mode is set.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bp_mode) begin
                if (bus.out_valid && bp_left > 0) begin
                    bus.out_ready = 1'b0;
                    bp_left--;
                end else begin
                    bus.out_ready = 1'b1;
                end
            end else begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: latency counts the edge at which the result can first be taken.
    initial begin
        exp_t        e;
        logic [31:0] held_q;
        logic [3:0]  held_f;
        holding = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                holding = 1'b0;
            end else if (bus.out_valid) begin
                if (!holding) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_result: got q=%h, expected no result", bus.q);
                    end else begin
                        e = sb.pop_front();
                        check32("q", bus.q, e.q);
                        check32("flags", 32'(dut_flags()), 32'(e.f));
                        check32("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    end
                    held_q  = bus.q;
                    held_f  = dut_flags();
                    holding = 1'b1;
                end else begin
                    check32("hold_q", bus.q, held_q);
                    check32("hold_flags", 32'(dut_flags()), 32'(held_f));
                end
                check32("busy_in_ready", 32'(bus.in_ready), 32'd0);
                if (bus.out_ready) holding = 1'b0;
            end
        end
    end

    initial begin
        tests        = 0;
        fails        = 0;
        bp_mode      = 1'b0;
        bp_left      = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = 32'd0;
        bus.b        = 32'd0;

        repeat (3) @(negedge clk);
        #1;
        check32("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check32("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check32("rst_q", bus.q, 32'd0);
        check32("rst_flags", 32'(dut_flags()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue_dir(32'h40400000, 32'h3FC00000, 32'h40000000, 4'b0000, 28);
        issue_dir(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28);
        issue_dir(32'hC0300000, 32'h40000000, 32'hBFB00000, 4'b0000, 28);
        issue_dir(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1);
        issue_dir(32'h00000000, 32'h80000000, 32'h7FC00000, 4'b1000, 1);
        issue_dir(32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, 1);
        issue_dir(32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 4'b0010, 28);
        issue_dir(32'h00800000, 32'h7F7FFFFF, 32'h00000000, 4'b0001, 28);
        issue_dir(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 1);
        wait_idle();

        // Stalled consumer plus junk requests while the loop is running.
        bp_mode = 1'b1;
        bp_left = 5;
        issue_dir(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28);
        repeat (5) begin
            bus.in_valid = 1'b1;
            bus.a        = $urandom;
            bus.b        = $urandom;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        wait_idle();
        bp_mode = 1'b0;
        issue_dir(32'hC0300000, 32'h40000000, 32'hBFB00000, 4'b0000, 28);
        wait_idle();

        // Reset in the middle of the mantissa loop discards the operation.
        issue_dir(32'h40400000, 32'h3FC00000, 32'h40000000, 4'b0000, 28);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check32("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check32("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check32("midrst_q", bus.q, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue_dir(32'h40400000, 32'h3FC00000, 32'h40000000, 4'b0000, 28);
        wait_idle();

        repeat (40) issue_rand(rand_fp(), rand_fp());
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
